// File: rtl/seg_scan_mux.sv
// Multiplexed N-digit seven-segment scanner with per-frame snapshot, decimal points,
// leading-zero blanking and adjust-mode blinking. All pins are active low.
module seg_scan_mux #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLINK_DIV   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  adj,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  lzb,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_tick
);

    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned PW = $clog2(REFRESH_DIV);
    localparam int unsigned FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [IW-1:0] IdxMax  = IW'(DIGITS - 1);
    localparam logic [PW-1:0] PcntMax = PW'(REFRESH_DIV - 1);
    localparam logic [FW-1:0] FcntMax = FW'(BLINK_DIV - 1);

    logic [PW-1:0]         pcnt_q, pcnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [FW-1:0]         fcnt_q, fcnt_d;
    logic                  bphase_q, bphase_d;
    logic                  first_q;
    logic [4*DIGITS-1:0]   sh_digits_q;
    logic [DIGITS-1:0]     sh_dp_q, sh_mask_q;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic                  frame_tick_q;

    logic                  adv, load;
    logic [3:0]            cur_val;
    logic                  cur_dp, cur_mask, lz_blank, run_zero, blank;

    function automatic logic [6:0] decode(input logic [3:0] v);
        unique case (v)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        adv      = (pcnt_q == PcntMax);
        load     = (adv && (idx_q == '0)) || first_q;
        pcnt_d   = adv ? '0 : pcnt_q + 1'b1;
        idx_d    = idx_q;
        fcnt_d   = fcnt_q;
        bphase_d = bphase_q;
        if (adv) begin
            idx_d = (idx_q == '0) ? IdxMax : idx_q - 1'b1;
        end
        if (load) begin
            if (fcnt_q == FcntMax) begin
                fcnt_d   = '0;
                bphase_d = ~bphase_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    // Walk digits from the top so run_zero tells whether digit i and everything above it is 0.
    always_comb begin
        cur_val  = '0;
        cur_dp   = 1'b0;
        cur_mask = 1'b0;
        lz_blank = 1'b0;
        run_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run_zero = run_zero && (sh_digits_q[4*i +: 4] == 4'd0);
            if (idx_q == IW'(i)) begin
                cur_val  = sh_digits_q[4*i +: 4];
                cur_dp   = sh_dp_q[i];
                cur_mask = sh_mask_q[i];
                lz_blank = lzb && run_zero && (i != 0);
            end
        end
        // Nothing is shown until the first snapshot has been taken.
        blank = first_q || lz_blank || (adj && cur_mask && bphase_q);
        seg_d = blank ? 7'h7F : decode(cur_val);
        dp_d  = blank | ~cur_dp;
        an_d  = blank ? '1 : ~(DIGITS'(1) << idx_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcnt_q       <= '0;
            idx_q        <= IdxMax;
            fcnt_q       <= '0;
            bphase_q     <= 1'b0;
            first_q      <= 1'b1;
            sh_digits_q  <= '0;
            sh_dp_q      <= '0;
            sh_mask_q    <= '0;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            an_q         <= '1;
            frame_tick_q <= 1'b0;
        end else begin
            pcnt_q       <= pcnt_d;
            idx_q        <= idx_d;
            fcnt_q       <= fcnt_d;
            bphase_q     <= bphase_d;
            first_q      <= 1'b0;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_tick_q <= load;
            if (load) begin
                sh_digits_q <= digits_in;
                sh_dp_q     <= dp_in;
                sh_mask_q   <= blink_mask;
            end
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: a time-indexed reference model pushes expected pins each edge;
// scenario tasks pop and compare them, plus a few direct checks from the test plan.
module tb_seg_scan_mux;

    localparam int D = 4;
    localparam int R = 4;
    localparam int B = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [4*D-1:0] digits_in;
    logic [D-1:0]   dp_in, blink_mask;
    logic           adj, lzb;
    logic [6:0]     seg;
    logic           dp;
    logic [D-1:0]   an;
    logic           frame_tick;

    typedef struct packed {
        logic [6:0]   seg;
        logic         dp;
        logic [D-1:0] an;
        logic         ft;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    seg_scan_mux #(.DIGITS(D), .REFRESH_DIV(R), .BLINK_DIV(B)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .adj        (adj),
        .blink_mask (blink_mask),
        .lzb        (lzb),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        logic [6:0] t [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        if (v > 4'd9) return 7'h7F;
        return t[v];
    endfunction

    // Model: edge k after release; loads at k==1 and every D*R edges; the pins after
    // edge k show the digit that was selected before that edge.
    int             m_k, m_loads;
    logic [4*D-1:0] m_dig;
    logic [D-1:0]   m_dp, m_mask;

    always @(posedge clk) begin
        exp_t e;
        int   d;
        logic ld, off;
        if (!rst_n) begin
            m_k = 0; m_loads = 0; m_dig = '0; m_dp = '0; m_mask = '0;
            e = '{seg: 7'h7F, dp: 1'b1, an: '1, ft: 1'b0};
        end else begin
            m_k = m_k + 1;
            ld  = (m_k == 1) || (m_k % (D * R) == 0);
            d   = D - 1 - (((m_k - 1) / R) % D);
            off = (m_k == 1)
               || (lzb && d >= 1 && ((m_dig >> (4 * d)) == '0))
               || (adj && m_mask[d] && (((m_loads / B) % 2) == 1));
            if (off) e = '{seg: 7'h7F, dp: 1'b1, an: '1, ft: ld};
            else     e = '{seg: ref_seg(m_dig[4*d +: 4]), dp: ~m_dp[d],
                           an: ~(D'(1) << d), ft: ld};
            if (ld) begin
                m_dig = digits_in; m_dp = dp_in; m_mask = blink_mask;
                m_loads = m_loads + 1;
            end
        end
        exp_q.push_back(e);
    end

    function automatic exp_t pop_exp();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    task automatic test_reset();
        exp_t e, got;
        digits_in = 16'($urandom); dp_in = 4'($urandom); adj = 1'($urandom);
        blink_mask = 4'($urandom); lzb = 1'($urandom);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            e = pop_exp(); got = {seg, dp, an, frame_tick};
            n_checks++;
            if (got !== e || got !== 13'({7'h7F, 1'b1, 4'hF, 1'b0})) begin
                n_fails++;
                $display("FAIL reset c%0d: got %h expected %h", c, got, e);
            end
            digits_in = 16'($urandom); dp_in = 4'($urandom); adj = 1'($urandom);
            blink_mask = 4'($urandom); lzb = 1'($urandom);
        end
        digits_in = 16'h1234; dp_in = 4'b0100; adj = 0; blink_mask = '0; lzb = 0;
        rst_n = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            e = pop_exp(); got = {seg, dp, an, frame_tick};
            n_checks++;
            if (got !== e || frame_tick !== (c == 1)) begin
                n_fails++;
                $display("FAIL release c%0d: got %h ft=%b expected %h", c, got, frame_tick, e);
            end
        end
    endtask

    task automatic test_scan();
        exp_t e, got;
        int   ticks = 0, bad_dp = 0;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            e = pop_exp(); got = {seg, dp, an, frame_tick};
            if (frame_tick) ticks++;
            if (!dp && an !== 4'b1011) bad_dp++;
            n_checks++;
            if (got !== e) begin
                n_fails++;
                $display("FAIL scan c%0d: got %h expected %h", c, got, e);
            end
        end
        n_checks++;
        if (ticks != 2 || bad_dp != 0) begin
            n_fails++;
            $display("FAIL scan_ticks: got ticks=%0d bad_dp=%0d expected 2 and 0", ticks, bad_dp);
        end
    endtask

    task automatic test_snapshot();
        exp_t e, got;
        logic found = 0, seen_ft = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            e = pop_exp(); got = {seg, dp, an, frame_tick};
            found = (an === 4'b1011);
            n_checks++;
            if (got !== e) begin
                n_fails++;
                $display("FAIL snap_wait c%0d: got %h expected %h", c, got, e);
            end
        end
        n_checks++;
        if (!found) begin
            n_fails++;
            $display("FAIL snap_find: got no an=1011 expected within 40 cycles");
        end
        digits_in = 16'h5678;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            e = pop_exp(); got = {seg, dp, an, frame_tick};
            if (frame_tick) seen_ft = 1;
            n_checks++;
            if (got !== e || (!seen_ft && an === 4'b1101 && seg !== 7'h30)) begin
                n_fails++;
                $display("FAIL snapshot c%0d: got %h expected %h", c, got, e);
            end
        end
    endtask

    task automatic test_blink();
        exp_t e, got;
        adj = 1'b1; blink_mask = 4'b0001;
        for (int c = 0; c < 160; c++) begin
            @(negedge clk);
            e = pop_exp(); got = {seg, dp, an, frame_tick};
            n_checks++;
            if (got !== e) begin
                n_fails++;
                $display("FAIL blink c%0d: got %h expected %h", c, got, e);
            end
        end
        adj = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            e = pop_exp(); got = {seg, dp, an, frame_tick};
            n_checks++;
            if (got !== e) begin
                n_fails++;
                $display("FAIL blink_off c%0d: got %h expected %h", c, got, e);
            end
        end
        blink_mask = '0;
    endtask

    task automatic test_lzb();
        exp_t e, got;
        int   lit = 0, wrong = 0;
        lzb = 1'b1; digits_in = 16'h0050; dp_in = 4'b1111;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            e = pop_exp(); got = {seg, dp, an, frame_tick};
            n_checks++;
            if (got !== e) begin
                n_fails++;
                $display("FAIL lzb_0050 c%0d: got %h expected %h", c, got, e);
            end
        end
        digits_in = 16'h0000;
        for (int c = 0; c < 48; c++) begin
            @(negedge clk);
            e = pop_exp(); got = {seg, dp, an, frame_tick};
            if (c >= 32 && an !== 4'b1111) begin
                lit++;
                if (an !== 4'b1110 || seg !== 7'h40) wrong++;
            end
            n_checks++;
            if (got !== e) begin
                n_fails++;
                $display("FAIL lzb_0000 c%0d: got %h expected %h", c, got, e);
            end
        end
        n_checks++;
        if (lit != R || wrong != 0) begin
            n_fails++;
            $display("FAIL lzb_only_d0: got lit=%0d wrong=%0d expected %0d and 0", lit, wrong, R);
        end
        lzb = 1'b0; dp_in = '0;
    endtask

    task automatic test_invalid_and_reset();
        exp_t e, got;
        logic found = 0;
        digits_in = 16'hA000;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            e = pop_exp(); got = {seg, dp, an, frame_tick};
            n_checks++;
            if (got !== e || (c >= 20 && an === 4'b0111 && seg !== 7'h7F)) begin
                n_fails++;
                $display("FAIL invalid c%0d: got %h expected %h", c, got, e);
            end
        end
        for (int c = 0; c < 32 && !found; c++) begin
            @(negedge clk);
            e = pop_exp(); got = {seg, dp, an, frame_tick};
            found = (an === 4'b1101);
            n_checks++;
            if (got !== e) begin
                n_fails++;
                $display("FAIL mid_wait c%0d: got %h expected %h", c, got, e);
            end
        end
        n_checks++;
        if (!found) begin
            n_fails++;
            $display("FAIL mid_find: got no an=1101 expected within 32 cycles");
        end
        rst_n = 1'b0;
        @(negedge clk);
        e = pop_exp(); got = {seg, dp, an, frame_tick};
        n_checks++;
        if (got !== e || got !== 13'({7'h7F, 1'b1, 4'hF, 1'b0})) begin
            n_fails++;
            $display("FAIL mid_reset: got %h expected %h", got, e);
        end
        rst_n = 1'b1; digits_in = 16'h9081;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            e = pop_exp(); got = {seg, dp, an, frame_tick};
            n_checks++;
            if (got !== e) begin
                n_fails++;
                $display("FAIL post_reset c%0d: got %h expected %h", c, got, e);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; digits_in = '0; dp_in = '0; adj = 0; blink_mask = '0; lzb = 0;
        test_reset();
        test_scan();
        test_snapshot();
        test_blink();
        test_lzb();
        test_invalid_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Parametrised N-digit multiplexed seven-segment driver for the stopwatch display path. It sits between the time-keeping counters and the board's common-anode display pins. It generates its own digit refresh rate and latches a per-frame snapshot so the display never tears. It adds decimal points, leading-zero blanking, and per-digit blinking for adjust mode.

## Interface
- `DIGITS`, 4: number of digits scanned; legal range 1..8.
- `REFRESH_DIV`, 100000: `clk` cycles each digit stays lit; minimum 2.
- `BLINK_DIV`, 32: frames per blink half-period; minimum 1.

- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `digits_in` in 4*DIGITS: BCD digits; bits [4i+3:4i] belong to digit i; digit 0 is rightmost.
- `dp_in` in DIGITS: decimal-point request per digit, active high.
- `adj` in 1: adjust mode; enables blinking.
- `blink_mask` in DIGITS: digits that blink while `adj`=1.
- `lzb` in 1: leading-zero blanking enable.
- `seg` out 7: segments {g,f,e,d,c,b,a}, active low.
- `dp` out 1: decimal point, active low.
- `an` out DIGITS: digit enables, active low; at most one bit low.
- `frame_tick` out 1: one-cycle pulse when a new snapshot is loaded.

## Operation
- **Prescaler:** `pcnt` counts 0..REFRESH_DIV-1 and wraps. `adv` = (`pcnt`==REFRESH_DIV-1).
- **Scan index:** `idx` resets to DIGITS-1. On `adv` it decrements, and wraps from 0 back to DIGITS-1. With DIGITS=1, `idx` stays at 0.
- **Snapshot:** `digits_in`, `dp_in` and `blink_mask` are copied into shadow registers when `load` = (`adv` && `idx`==0) || `first`.
  - `first` is set by reset and cleared on the first cycle after reset release.
  - `frame_tick` is registered from `load`.
  - All digits of one frame come from the same snapshot.
- **Blink:**
  - `fcnt` counts loads from 0..BLINK_DIV-1.
  - `bphase` toggles on the load where `fcnt` wraps.
  - Digit i is blanked when `adj` && shadow `blink_mask`[i] && `bphase`.
  - `adj` is sampled live, not snapshotted.
  - When `adj`=0, nothing blinks, but `fcnt` and `bphase` keep running.
- **Leading-zero blanking** (`lzb`=1):
  - Digit i (i≥1) is blanked when its shadow value and the values of all digits above it are 0.
  - Digit 0 is never blanked by this rule.
  - A digit blanked by this rule also suppresses its `dp`.
- **Decode:**

  | Value | `seg` |
  |---|---|
  | 0 | 7'b1000000 |
  | 1 | 7'b1111001 |
  | 2 | 7'b0100100 |
  | 3 | 7'b0110000 |
  | 4 | 7'b0011001 |
  | 5 | 7'b0010010 |
  | 6 | 7'b0000010 |
  | 7 | 7'b1111000 |
  | 8 | 7'b0000000 |
  | 9 | 7'b0010000 |
  | 10..15 | 7'b1111111 (all off) |

- **Blanked digit:**
  - Its `an` bit stays high.
  - `seg`=7'h7F and `dp`=1.
- **Unblanked digit `idx`:**
  - `an` = ~(1<<`idx`).
  - `seg` = decode(shadow digit).
  - `dp` = ~shadow `dp_in`[`idx`].

## Timing
- **Reset values** (one edge with `rst_n`=0):
  - `seg`=7'h7F, `dp`=1, `an`=all ones, `frame_tick`=0.
  - `pcnt`=0, `idx`=DIGITS-1, `fcnt`=0, `bphase`=0, shadows=0, `first`=1.
- **Output register:** `seg`, `dp` and `an` are registered from `idx` and the shadows, so they lag an `idx` change by one cycle.
- **After reset release:**
  - Cycle 1: snapshot loaded, `frame_tick`=1.
  - Cycle 2: digit DIGITS-1 is driven.
- **Steady state:**
  - Each digit is lit for exactly REFRESH_DIV cycles.
  - Frame period is DIGITS*REFRESH_DIV cycles.
  - Blink period is 2*BLINK_DIV frames.
- **Input latency:** a change on `digits_in`, `dp_in` or `blink_mask` appears on the pins 2 cycles after the next `load`, never mid-frame.
- **`adj` / `lzb` changes:** take effect on the pins 1 cycle after they change.
- **Reset mid-scan:** all state returns to reset values on the next edge, regardless of `pcnt` or `idx`.
- **Simultaneous events:** `load` and a `bphase` toggle on the same edge are both applied. The new phase governs the new frame.

## Test plan
Parameters for all scenarios: DIGITS=4, REFRESH_DIV=4, BLINK_DIV=2.

1. **Reset:** hold `rst_n`=0 for 3 cycles with random inputs -> `seg`=7F, `dp`=1, `an`=1111, `frame_tick`=0 throughout. After release, `frame_tick` pulses once at cycle 1.
2. **Scan:** `digits_in`=16'h1234, `dp_in`=4'b0100 -> `an` sequence 0111, 1011, 1101, 1110, each held 4 cycles.
   - `seg` sequence 79, 24, 30, 19.
   - `dp`=0 only while `an`=1011.
   - `frame_tick` pulses every 16 cycles.
3. **Snapshot:** change `digits_in` to 16'h5678 while `an`=1011 -> digits 2..0 still show 2, 3, 4. The next frame shows 12, 02, 78, 00 (seg hex).
4. **Blink:** `adj`=1, `blink_mask`=0001 -> digit 0 is lit during 2 frames and dark (`an`=1111, `seg`=7F) during the next 2 frames, repeating. Setting `adj`=0 restores digit 0 within 1 cycle.
5. **Leading-zero blanking:**
   - `lzb`=1, `digits_in`=16'h0050 -> digits 3 and 2 dark; digit 1 shows 12; digit 0 shows 40.
   - `digits_in`=16'h0000 -> only digit 0 is lit, showing 40.
6. **Invalid code / reset mid-scan:**
   - `digits_in`=16'hA000 -> digit 3 shows `seg`=7F while `an`=0111.
   - Assert `rst_n`=0 while `idx`=1 -> reset values appear at the next edge.
